seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked ALU that generalises the team's combinational 16-bit signed ALU. It is width-configurable, adds iterative multiply and (optionally) divide, and produces status flags. It sits between the decode/issue stage and writeback. It accepts one operation at a time over a valid/ready interface and returns the result over a second valid/ready interface.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be ≥ 4 and a power of two.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active low.
- `in_valid` input, 1 bit: an operation is presented.
- `in_ready` output, 1 bit: the block can accept an operation.
- `op` input, 3 bits: opcode, `alu_op_t`.
- `lhs` input, WIDTH bits: signed left operand.
- `rhs` input, WIDTH bits: signed right operand.
- `out_valid` output, 1 bit: result is available.
- `out_ready` input, 1 bit: consumer takes the result.
- `result` output, WIDTH bits: signed result.
- `flag_z` output, 1 bit: result == 0.
- `flag_n` output, 1 bit: `result[WIDTH-1]`.
- `flag_v` output, 1 bit: signed overflow (ADD/SUB), or the MIN/−1 divide case.
- `flag_dz` output, 1 bit: divide by zero.

## Operation
- Opcodes:
  - 0 ADD: lhs+rhs.
  - 1 SUB: lhs−rhs.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: lhs << rhs[log2(WIDTH)−1:0].
  - 6 MUL: low WIDTH bits of the signed product.
  - 7 DIV: signed quotient, truncated toward zero.
- All arithmetic wraps modulo 2^WIDTH.
- ADD/SUB `flag_v`: both operands of the effective addition have the same sign and the result sign differs.
- DIV boundaries:
  - rhs=0 → result all ones, `flag_dz`=1, `flag_v`=0.
  - lhs=MIN, rhs=−1 → result MIN, `flag_v`=1.
- `flag_v`=0 and `flag_dz`=0 for every other op.
- `flag_z` and `flag_n` always reflect `result`.
- FSM states:
  - IDLE: `in_ready`=1. Accept on `in_valid`. Simple ops (0–5) go to DONE. MUL/DIV go to ITER with counter=WIDTH.
  - ITER: one shift-add (MUL) or restoring-subtract on magnitudes (DIV) per cycle. Counter decrements. At counter=0 go to FIX.
  - FIX: apply sign correction (DIV) and boundary cases. Go to DONE.
  - DONE: `out_valid`=1. On `out_ready` go to IDLE.
- Outputs are registered and held stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in ITER, FIX and DONE. No new operation is accepted in the cycle a result is taken.

## Timing
- Accept edge = rising edge with `in_valid`&`in_ready`.
- Simple ops: `out_valid` rises at the edge after accept (latency 1).
- MUL/DIV: `out_valid` rises WIDTH+1 edges after accept (WIDTH iterations plus FIX); 17 for WIDTH=16.
- Result is consumed at the edge with `out_valid`&`out_ready`. `in_ready` is 1 from the following cycle.
- Reset values: FSM=IDLE; `in_ready`=1; `out_valid`=0; `result`=0; all flags 0; counter=0.
- Reset mid-ITER or in DONE discards the operation with no output. The first cycle after release is IDLE.
- `op`/`lhs`/`rhs` are sampled only at the accept edge; later changes have no effect.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV is implemented as specified.
- `SEQ_ALU_DIV_EN` undefined:
  - DIV datapath is omitted.
  - op 7 completes with simple-op latency 1, result 0, `flag_dz`=1, `flag_v`=0.
  - MUL is unaffected.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum with the encodings above.
  - `seq_alu_state_t` for the FSM.
  - `alu_flags_t` struct {z,n,v,dz}.
- Sub-module `seq_alu_muldiv`: iterative engine with start/done, parametrised by WIDTH, under the `SEQ_ALU_DIV_EN` guard for the divide path.
- Top: handshake FSM and single-cycle datapath.

## Test plan
All cases WIDTH=16.
- SUB sweep: lhs 2..29 × rhs 2..29, `out_ready`=1 → result lhs−rhs each time, 1-cycle latency; lhs=2, rhs=29 → −27, `flag_n`=1.
- ADD overflow: 32767+1 → −32768, `flag_v`=1, `flag_n`=1; SUB 5−5 → 0, `flag_z`=1.
- MUL: −7×6 → −42 with `out_valid` exactly 17 edges after accept; 300×300 → 24464 (wrapped).
- DIV (macro on): −7/2 → −3; 7/0 → 0xFFFF with `flag_dz`=1; −32768/−1 → −32768 with `flag_v`=1. Macro off: 7/2 → 0 with `flag_dz`=1 at latency 1.
- Backpressure: `out_ready`=0 for 5 cycles after AND 0x0F0F & 0x00FF → `result` holds 0x000F and `in_ready` stays 0; released → `in_ready`=1 the next cycle.
- Reset mid-MUL: assert `rst_n`=0 at iteration 8 → `out_valid`=0, `in_ready`=1 after release, and the next ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, handshake FSM states
// and the status flag bundle. Also holds the helper that decides which
// opcodes run on the iterative engine. SEQ_ALU_DIV_EN selects whether DIV
// is one of them.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_MUL = 3'd6,
      OP_DIV = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } seq_alu_state_t;

   typedef struct packed {
      logic z;
      logic n;
      logic v;
      logic dz;
   } alu_flags_t;

   // True for opcodes that take the multi-cycle path through the engine
   function automatic logic is_iterative(alu_op_t op);
`ifdef SEQ_ALU_DIV_EN
      return (op == OP_MUL) || (op == OP_DIV);
`else
      return (op == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / divide engine for seq_alu.
// start loads the operands; every cycle with step high performs one
// shift-add (MUL) or one restoring-subtract on operand magnitudes (DIV).
// After WIDTH steps the corrected result and flags are valid on the outputs.
// The divide path exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
`ifdef SEQ_ALU_DIV_EN
   input  logic             is_div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             flag_v,
   output logic             flag_dz
);

   // The low WIDTH bits of a signed product equal those of the unsigned
   // product of the two's complement patterns, so plain shift-add suffices.
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

`ifdef SEQ_ALU_DIV_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic             mode_div;
   logic             neg_q;
   logic             dz_q;
   logic             ovf_q;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;

   // Magnitude as an unsigned value; MIN maps to 2^(WIDTH-1), which still fits
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

   // Next partial remainder: shift in the next dividend bit, trial-subtract
   always_comb begin
      rem_sh  = {rem, quo[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, dvs};
   end
`endif

   // Operand load on start, one iteration per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
`ifdef SEQ_ALU_DIV_EN
         mode_div <= 1'b0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         dvs      <= '0;
         quo      <= '0;
         rem      <= '0;
`endif
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
`ifdef SEQ_ALU_DIV_EN
         mode_div <= is_div;
         neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
         dz_q     <= (b == '0);
         ovf_q    <= (a == MIN_VAL) && (b == '1);
         dvs      <= mag(b);
         quo      <= mag(a);
         rem      <= '0;
`endif
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
`ifdef SEQ_ALU_DIV_EN
         if (rem_sh >= {1'b0, dvs}) begin
            rem <= rem_sub[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
         end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
         end
`endif
      end
   end

   // Final result: product as is, or quotient with sign and boundary fixes
   always_comb begin
      result  = acc;
      flag_v  = 1'b0;
      flag_dz = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      if (mode_div) begin
         if (dz_q) begin
            result  = '1;
            flag_dz = 1'b1;
         end else begin
            // MIN / -1: magnitude 2^(WIDTH-1) stays positive and reads back
            // as MIN, so only the overflow flag needs raising.
            result = neg_q ? (~quo + 1'b1) : quo;
            flag_v = ovf_q;
         end
      end
`endif
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked, width-configurable signed ALU.
// One operation at a time: accepted over in_valid/in_ready, returned over
// out_valid/out_ready. Simple ops complete in one step; MUL (and DIV when
// SEQ_ALU_DIV_EN is defined) run WIDTH iterations in seq_alu_muldiv plus
// a fix-up cycle. WIDTH must be a power of two and at least 4.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and result/flags stay stable
// while out_valid is high and out_ready is low.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_dz,
   output seq_alu_state_t   dbg_state
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   seq_alu_state_t   state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res_q;
   alu_flags_t       flg_q;

   alu_op_t          op_e;
   logic             accept;
   logic             eng_start;
   logic             eng_step;
   logic [WIDTH-1:0] eng_res;
   logic             eng_v;
   logic             eng_dz;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] simple_res;
   logic             simple_v;
   logic             simple_dz;

   assign op_e      = alu_op_t'(op);
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign eng_start = accept && is_iterative(op_e);
   assign eng_step  = (state == ST_ITER);
   assign sum       = lhs + rhs;
   assign diff      = lhs - rhs;

   assign result    = res_q;
   assign flag_z    = flg_q.z;
   assign flag_n    = flg_q.n;
   assign flag_v    = flg_q.v;
   assign flag_dz   = flg_q.dz;
   assign dbg_state = state;

   // Single-cycle datapath for the simple opcodes
   always_comb begin
      simple_res = '0;
      simple_v   = 1'b0;
      simple_dz  = 1'b0;
      case (op_e)
         OP_ADD: begin
            simple_res = sum;
            simple_v   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
         end
         OP_SUB: begin
            // Effective addition is lhs + (-rhs): operand signs differ here
            simple_res = diff;
            simple_v   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (diff[WIDTH-1] != lhs[WIDTH-1]);
         end
         OP_AND: simple_res = lhs & rhs;
         OP_OR:  simple_res = lhs | rhs;
         OP_XOR: simple_res = lhs ^ rhs;
         OP_SHL: simple_res = lhs << rhs[SHW-1:0];
`ifndef SEQ_ALU_DIV_EN
         OP_DIV: simple_dz = 1'b1;
`endif
         default: simple_res = '0;
      endcase
   end

   seq_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (eng_start),
      .step    (eng_step),
`ifdef SEQ_ALU_DIV_EN
      .is_div  (op_e == OP_DIV),
`endif
      .a       (lhs),
      .b       (rhs),
      .result  (eng_res),
      .flag_v  (eng_v),
      .flag_dz (eng_dz)
   );

   // Handshake FSM with registered result and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (is_iterative(op_e)) begin
                     cnt   <= CW'(WIDTH);
                     state <= ST_ITER;
                  end else begin
                     res_q    <= simple_res;
                     flg_q.z  <= (simple_res == '0);
                     flg_q.n  <= simple_res[WIDTH-1];
                     flg_q.v  <= simple_v;
                     flg_q.dz <= simple_dz;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_ITER: begin
               // The engine steps on this same edge; leave once the last one lands
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               res_q    <= eng_res;
               flg_q.z  <= (eng_res == '0);
               flg_q.n  <= eng_res[WIDTH-1];
               flg_q.v  <= eng_v;
               flg_q.dz <= eng_dz;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=16. A plain-arithmetic model
// predicts every result; one compare process checks result, flags, latency
// and in_ready on every cycle out_valid is high. Directed cases pin the
// model with literal values. Build with SEQ_ALU_DIV_EN to cover the divider.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W    = 16;
   localparam int MAXV = 2 ** (W - 1) - 1;
   localparam int MINV = -(2 ** (W - 1));

   // ---------------- clock / reset / DUT ----------------
   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           out_ready = 1'b1;
   logic [2:0]     op        = '0;
   logic [W-1:0]   lhs       = '0;
   logic [W-1:0]   rhs       = '0;
   logic           in_ready;
   logic           out_valid;
   logic [W-1:0]   result;
   logic           flag_z;
   logic           flag_n;
   logic           flag_v;
   logic           flag_dz;
   seq_alu_state_t dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .lhs       (lhs),
      .rhs       (rhs),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_v    (flag_v),
      .flag_dz   (flag_dz),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int           n_vec  = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [3:0]   expf_q[$];
   int           due_q[$];
   logic         have_cur = 1'b0;
   logic [W-1:0] cur_res;
   logic [3:0]   cur_flg;
   int           cur_due;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Model. off = edges from the accept edge to the edge where out_valid
   // rises: simple ops show out_valid in the very next cycle, MUL/DIV need
   // WIDTH iterations plus one fix-up edge. Flags are {z,n,v,dz}.
   function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [3:0] f, output int off);
      longint sa;
      longint sb;
      longint wide;
      logic   v;
      logic   dz;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      wide = 0;
      v    = 1'b0;
      dz   = 1'b0;
      off  = 0;
      r    = '0;
      case (o)
         3'd0: begin wide = sa + sb; r = wide[W-1:0]; v = (wide > MAXV) || (wide < MINV); end
         3'd1: begin wide = sa - sb; r = wide[W-1:0]; v = (wide > MAXV) || (wide < MINV); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = a << b[$clog2(W)-1:0];
         3'd6: begin wide = sa * sb; r = wide[W-1:0]; off = W + 1; end
         default: begin
`ifdef SEQ_ALU_DIV_EN
            off = W + 1;
            if (sb == 0) begin
               r  = '1;
               dz = 1'b1;
            end else if (sa == MINV && sb == -1) begin
               wide = MINV;
               r    = wide[W-1:0];
               v    = 1'b1;
            end else begin
               wide = sa / sb;
               r    = wide[W-1:0];
            end
`else
            r  = '0;
            dz = 1'b1;
`endif
         end
      endcase
      f = {(r == '0), r[W-1], v, dz};
   endfunction

   // Compare process: every cycle a result is presented
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         expf_q.delete();
         due_q.delete();
         have_cur = 1'b0;
      end else if (out_valid) begin
         if (!have_cur) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               cur_res  = exp_q.pop_front();
               cur_flg  = expf_q.pop_front();
               cur_due  = due_q.pop_front();
               have_cur = 1'b1;
               check("latency_cycle", 32'(cyc), 32'(cur_due));
            end
         end
         if (have_cur) begin
            check("result", 32'(result), 32'(cur_res));
            check("flags_znvd", 32'({flag_z, flag_n, flag_v, flag_dz}), 32'(cur_flg));
            check("in_ready_while_out_valid", 32'(in_ready), 32'd0);
            if (out_ready) have_cur = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [3:0]   f;
      int           off;
      int           n;
      n = 0;
      while (!in_ready && n < 100) begin
         sync();
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      model(o, a, b, r, f, off);
      exp_q.push_back(r);
      expf_q.push_back(f);
      due_q.push_back(cyc + 1 + off);
      in_valid = 1'b1;
      op       = o;
      lhs      = a;
      rhs      = b;
      sync();
      // Scramble the operand bus: only the accept-edge values may matter
      in_valid = 1'b0;
      op       = 3'($urandom_range(0, 7));
      lhs      = W'($urandom_range(0, 65535));
      rhs      = W'($urandom_range(0, 65535));
   endtask

   // Literal pin: waits for the next presented result and compares it
   task automatic wait_out(input string name, input logic [W-1:0] r, input logic [3:0] f);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_res"}, 32'(result), 32'(r));
      check({name, "_flags"}, 32'({flag_z, flag_n, flag_v, flag_dz}), 32'(f));
      sync();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || have_cur) && n < 100) begin
         sync();
         n++;
      end
      if (exp_q.size() != 0 || have_cur) begin
         check("drain_pending", 32'(exp_q.size()), 32'd0);
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [2:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   vec_t mix[8];

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({flag_z, flag_n, flag_v, flag_dz}), 32'd0);
      sync();
      rst_n = 1'b1;
      sync();

      // SUB sweep, out_ready held high
      for (int l = 2; l <= 29; l++) begin
         for (int r = 2; r <= 29; r++) begin
            send(3'd1, W'(l), W'(r));
         end
      end
      drain();
      send(3'd1, 16'd2, 16'd29);
      wait_out("sub_2_29", 16'hFFE5, 4'b0100);

      // ADD overflow and zero result
      send(3'd0, 16'h7FFF, 16'h0001);
      wait_out("add_ovf", 16'h8000, 4'b0110);
      send(3'd1, 16'd5, 16'd5);
      wait_out("sub_zero", 16'h0000, 4'b1000);

      // Logic and shift mix, checked by the model only
      mix[0] = '{3'd3, 16'hF000, 16'h000F};
      mix[1] = '{3'd4, 16'hAAAA, 16'hFFFF};
      mix[2] = '{3'd5, 16'h0003, 16'h0014};
      mix[3] = '{3'd5, 16'h0001, 16'h000F};
      mix[4] = '{3'd1, 16'h8000, 16'h0001};
      mix[5] = '{3'd0, 16'h8000, 16'h8000};
      mix[6] = '{3'd6, 16'hFFFF, 16'hFFFF};
      mix[7] = '{3'd6, 16'h8000, 16'h0002};
      foreach (mix[i]) send(mix[i].o, mix[i].a, mix[i].b);
      drain();

      // MUL with latency checked by the compare process
      send(3'd6, 16'hFFF9, 16'd6);
      @(negedge clk);
      check("mul_busy_in_ready", 32'(in_ready), 32'd0);
      wait_out("mul_m7x6", 16'hFFD6, 4'b0100);
      send(3'd6, 16'd300, 16'd300);
      wait_out("mul_300x300", 16'd24464, 4'b0000);

      // DIV
`ifdef SEQ_ALU_DIV_EN
      send(3'd7, 16'hFFF9, 16'd2);
      wait_out("div_m7_2", 16'hFFFD, 4'b0100);
      send(3'd7, 16'd7, 16'd0);
      wait_out("div_by_zero", 16'hFFFF, 4'b0101);
      send(3'd7, 16'h8000, 16'hFFFF);
      wait_out("div_min_m1", 16'h8000, 4'b0110);
      send(3'd7, 16'd100, 16'hFFF9);
      send(3'd7, 16'h8000, 16'd1);
      drain();
`else
      send(3'd7, 16'd7, 16'd2);
      wait_out("div_disabled", 16'h0000, 4'b1001);
`endif

      // Backpressure: result must hold, no new accept
      out_ready = 1'b0;
      send(3'd2, 16'h0F0F, 16'h00FF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_result", 32'(result), 32'h000F);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      sync();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      sync();

      // Reset in the middle of a multiply
      send(3'd6, 16'd100, 16'd200);
      repeat (7) sync();
      rst_n = 1'b0;
      repeat (2) sync();
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      repeat (20) @(negedge clk);
      check("postrst_no_late_out", 32'(out_valid), 32'd0);
      sync();
      send(3'd0, 16'd3, 16'd4);
      wait_out("postrst_add", 16'd7, 4'b0000);

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
